// File: rtl/nbit_addsub_pipe.sv
// rtl/nbit_addsub_pipe.sv - segmented pipelined adder/subtractor with flags and valid/ready handshake
// Each stage adds one SEG-bit slice; unconsumed operand slices shrink stage by stage as results accumulate.
module nbit_addsub_pipe #(
  parameter int NBIT = 16,
  parameter int SEG  = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [NBIT-1:0] a_i,
  input  logic [NBIT-1:0] b_i,
  input  logic            sub_i,
  input  logic            signed_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [NBIT-1:0] result_o,
  output logic            carry_o,
  output logic            overflow_o,
  output logic            zero_o
);

  localparam int STAGES = NBIT / SEG;

  logic advance;

  assign advance = !valid_o || ready_i;
  assign ready_o = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // RW: operand bits still to be consumed when entering stage k
    localparam int RW = NBIT - k * SEG;

    logic                   v_d;
    logic                   c_d;
    logic                   sub_d;
    logic                   sgn_d;
    logic [RW-1:0]          a_d;
    logic [RW-1:0]          bp_d;
    logic [SEG:0]           sum;
    logic [(k+1)*SEG-1:0]   res_n;
    logic                   v_q;
    logic                   c_q;
    logic [(k+1)*SEG-1:0]   res_q;

    if (k == 0) begin : g_in
      assign v_d   = valid_i;
      assign a_d   = a_i;
      assign bp_d  = sub_i ? ~b_i : b_i;
      assign c_d   = sub_i;
      assign sub_d = sub_i;
      assign sgn_d = signed_i;
      assign res_n = sum[SEG-1:0];
    end else begin : g_in
      assign v_d   = g_stage[k-1].v_q;
      assign a_d   = g_stage[k-1].g_pass.a_q;
      assign bp_d  = g_stage[k-1].g_pass.bp_q;
      assign c_d   = g_stage[k-1].c_q;
      assign sub_d = g_stage[k-1].g_pass.sub_q;
      assign sgn_d = g_stage[k-1].g_pass.sgn_q;
      assign res_n = {sum[SEG-1:0], g_stage[k-1].res_q};
    end

    assign sum = {1'b0, a_d[SEG-1:0]} + {1'b0, bp_d[SEG-1:0]} + {{SEG{1'b0}}, c_d};

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        res_q <= '0;
      end else if (advance) begin
        v_q   <= v_d;
        c_q   <= sum[SEG];
        res_q <= res_n;
      end
    end

    if (k < STAGES - 1) begin : g_pass
      logic [RW-SEG-1:0] a_q;
      logic [RW-SEG-1:0] bp_q;
      logic              sub_q;
      logic              sgn_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          a_q   <= '0;
          bp_q  <= '0;
          sub_q <= 1'b0;
          sgn_q <= 1'b0;
        end else if (advance) begin
          a_q   <= a_d[RW-1:SEG];
          bp_q  <= bp_d[RW-1:SEG];
          sub_q <= sub_d;
          sgn_q <= sgn_d;
        end
      end
    end else begin : g_last
      logic ov_q;
      logic z_q;
      logic sov;
      logic uov;

      // Only the top slice remains here, so bit SEG-1 is the operand sign bit.
      assign sov = (a_d[SEG-1] == bp_d[SEG-1]) && (sum[SEG-1] != a_d[SEG-1]);
      assign uov = sub_d ? !sum[SEG] : sum[SEG];

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          ov_q <= 1'b0;
          z_q  <= 1'b0;
        end else if (advance) begin
          ov_q <= sgn_d ? sov : uov;
          z_q  <= (res_n == '0);
        end
      end
    end
  end

  assign valid_o    = g_stage[STAGES-1].v_q;
  assign result_o   = g_stage[STAGES-1].res_q;
  assign carry_o    = g_stage[STAGES-1].c_q;
  assign overflow_o = g_stage[STAGES-1].g_last.ov_q;
  assign zero_o     = g_stage[STAGES-1].g_last.z_q;

endmodule
